mac_pipe_sat: RTL and testbench
===============================

// Module: mac_pipe_sat
// PURPOSE
//  Parametrised, pipelined signed multiply-accumulate: f <= f + a*b per valid sample.
//  Next-generation accumulator datapath: generic widths, optional multiplier stage,
//  in-band accumulator clear, selectable saturation/wrap and a sticky overflow flag.
//  Streaming, no backpressure: one sample per cycle whenever valid_in=1.
// PARAMETERS
//  A_WIDTH    8   width of signed operands a, b
//  F_WIDTH    20  width of signed accumulator f; must satisfy F_WIDTH >= 2*A_WIDTH
//  PIPELINED  1   1: registered product stage (latency 3); 0: no product register (latency 2)
//  SATURATE   1   1: clamp on overflow; 0: two's-complement wrap
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  a          in   A_WIDTH  signed operand
//  b          in   A_WIDTH  signed operand
//  valid_in   in   1        a, b, clear_acc valid this cycle
//  clear_acc  in   1        sample restarts accumulation (f := a*b); ignored when valid_in=0
//  f          out  F_WIDTH  signed accumulator, registered
//  valid_out  out  1        one-cycle pulse: f just updated by a sample
//  overflow   out  1        sticky: a saturation/wrap occurred since last clear or reset
// BEHAVIOUR
//  - Reset: all pipeline registers, valid bits, f, valid_out, overflow := 0. In-flight
//    samples are discarded; no valid_out is issued for them.
//  - Stage 0: on valid_in=1 register a, b, clear_acc; v0 <= valid_in. Data regs hold when 0.
//  - Stage 1 (PIPELINED=1 only): on v0=1 prod_r <= a_r*b_r (2*A_WIDTH signed); v1 <= v0.
//  - Accumulate stage, on final valid bit = 1:
//      clear tag=1: f <= sign-extended product; overflow <= 0.
//      clear tag=0: sum = f + prod computed at F_WIDTH+1 bits.
//        sum in range: f <= sum.
//        sum > 2^(F_WIDTH-1)-1: SATURATE=1 -> f <= max positive; SATURATE=0 -> f <= sum
//        truncated to F_WIDTH. overflow <= 1 either way. Negative side symmetric (min value).
//      valid_out <= 1 next edge (same edge f updates).
//    Final valid bit = 0: f, overflow hold; valid_out <= 0.
//  - Latency valid_in -> valid_out/f: 3 cycles (PIPELINED=1), 2 cycles (PIPELINED=0).
//    Throughput 1 sample/cycle; valid_out pattern equals valid_in pattern, delayed.
//  - Product can never overflow F_WIDTH (width rule), so a cleared sample never sets overflow.
//  - Back-to-back samples, clear mid-stream: clear applies exactly to its tagged sample;
//    earlier in-flight samples accumulate into the old sum first, then f restarts.
//  - reset has priority over all other inputs on the same edge.
// TESTING (A_WIDTH=8, F_WIDTH=20 unless noted)
//  1. After reset, a=3,b=4,valid_in=1 one cycle -> f=12, valid_out=1 exactly at cycle 3, 0 after.
//  2. 32 consecutive (-128,-128), SATURATE=1 -> f=507904 after 31st; after 32nd f=524287,
//     overflow=1; SATURATE=0 -> f=-524288, overflow=1.
//  3. After test 2, send (5,6) with clear_acc=1 -> f=30, overflow=0.
//  4. valid_in pattern 1,0,1,1 with (1,2),(x),(3,3),(-4,5) -> valid_out 1,0,1,1; f 2,2,11,-9.
//  5. Two samples in flight, assert reset 1 cycle -> no valid_out, f=0, overflow=0; next sample
//     (7,7) -> f=49.
//  6. PIPELINED=0: repeat test 1 -> valid_out at cycle 2; test 4 results identical.

Source files
------------

// File: rtl/mac_pipe_sat.sv
// Pipelined signed multiply-accumulate: f <= f + a*b per valid sample, with an optional product
// register stage, in-band clear, saturate-or-wrap overflow handling and a sticky overflow flag.
module mac_pipe_sat #(
  parameter int A_WIDTH   = 8,
  parameter int F_WIDTH   = 20,
  parameter int PIPELINED = 1,
  parameter int SATURATE  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [A_WIDTH-1:0] b,
  input  logic                      valid_in,
  input  logic                      clear_acc,
  output logic signed [F_WIDTH-1:0] f,
  output logic                      valid_out,
  output logic                      overflow
);

  localparam int P_WIDTH = 2 * A_WIDTH;
  localparam int S_WIDTH = F_WIDTH + 1;
  localparam logic signed [F_WIDTH-1:0] F_MAX = {1'b0, {(F_WIDTH-1){1'b1}}};
  localparam logic signed [F_WIDTH-1:0] F_MIN = {1'b1, {(F_WIDTH-1){1'b0}}};

  // Stage 0: input capture; data registers only move on a valid sample
  logic signed [A_WIDTH-1:0] r_a;
  logic signed [A_WIDTH-1:0] r_b;
  logic                      r_clr0;
  logic                      r_v0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_clr0 <= 1'b0;
      r_v0   <= 1'b0;
    end else begin
      r_v0 <= valid_in;
      if (valid_in) begin
        r_a    <= a;
        r_b    <= b;
        r_clr0 <= clear_acc;
      end
    end
  end

  logic signed [P_WIDTH-1:0] w_a_ext;
  logic signed [P_WIDTH-1:0] w_b_ext;
  logic signed [P_WIDTH-1:0] w_mult;

  assign w_a_ext = P_WIDTH'(r_a);
  assign w_b_ext = P_WIDTH'(r_b);
  assign w_mult  = w_a_ext * w_b_ext;

  // Product seen by the accumulate stage, together with its clear tag and valid bit
  logic signed [P_WIDTH-1:0] w_prod;
  logic                      w_clr;
  logic                      w_v;

  generate
    if (PIPELINED != 0) begin : g_prod_reg
      logic signed [P_WIDTH-1:0] r_prod;
      logic                      r_clr1;
      logic                      r_v1;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_prod <= '0;
          r_clr1 <= 1'b0;
          r_v1   <= 1'b0;
        end else begin
          r_v1 <= r_v0;
          if (r_v0) begin
            r_prod <= w_mult;
            r_clr1 <= r_clr0;
          end
        end
      end

      assign w_prod = r_prod;
      assign w_clr  = r_clr1;
      assign w_v    = r_v1;
    end else begin : g_prod_comb
      assign w_prod = w_mult;
      assign w_clr  = r_clr0;
      assign w_v    = r_v0;
    end
  endgenerate

  // One guard bit is enough: |prod| <= 2^(F_WIDTH-2) by the width rule
  logic signed [S_WIDTH-1:0] w_f_ext;
  logic signed [S_WIDTH-1:0] w_prod_ext;
  logic signed [S_WIDTH-1:0] w_sum;
  logic signed [F_WIDTH-1:0] w_prod_f;
  logic signed [F_WIDTH-1:0] w_sum_trunc;
  logic                      w_ovf_pos;
  logic                      w_ovf_neg;
  logic signed [F_WIDTH-1:0] w_hi_val;
  logic signed [F_WIDTH-1:0] w_lo_val;

  assign w_f_ext     = S_WIDTH'(f);
  assign w_prod_ext  = S_WIDTH'(w_prod);
  assign w_sum       = w_f_ext + w_prod_ext;
  assign w_prod_f    = F_WIDTH'(w_prod);
  assign w_sum_trunc = w_sum[F_WIDTH-1:0];
  assign w_ovf_pos   = ~w_sum[F_WIDTH] &  w_sum[F_WIDTH-1];
  assign w_ovf_neg   =  w_sum[F_WIDTH] & ~w_sum[F_WIDTH-1];
  assign w_hi_val    = (SATURATE != 0) ? F_MAX : w_sum_trunc;
  assign w_lo_val    = (SATURATE != 0) ? F_MIN : w_sum_trunc;

  always_ff @(posedge clk) begin
    if (reset) begin
      f         <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid_out <= w_v;
      if (w_v) begin
        if (w_clr) begin
          f        <= w_prod_f;
          overflow <= 1'b0;
        end else if (w_ovf_pos) begin
          f        <= w_hi_val;
          overflow <= 1'b1;
        end else if (w_ovf_neg) begin
          f        <= w_lo_val;
          overflow <= 1'b1;
        end else begin
          f <= w_sum_trunc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Directed bench for mac_pipe_sat: three instances (pipelined+saturate, pipelined+wrap,
// unpipelined+saturate) share one stimulus stream and are checked at their own latencies.
module tb_mac_pipe_sat;

  logic               clk;
  logic               reset;
  logic signed [7:0]  a;
  logic signed [7:0]  b;
  logic               valid_in;
  logic               clear_acc;

  logic signed [19:0] f_p, f_w, f_n;
  logic               vo_p, vo_w, vo_n;
  logic               ov_p, ov_w, ov_n;

  int n_checks = 0;
  int n_errors = 0;

  mac_pipe_sat #(.A_WIDTH(8), .F_WIDTH(20), .PIPELINED(1), .SATURATE(1)) u_dut_p (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_p), .valid_out(vo_p), .overflow(ov_p));

  mac_pipe_sat #(.A_WIDTH(8), .F_WIDTH(20), .PIPELINED(1), .SATURATE(0)) u_dut_w (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_w), .valid_out(vo_w), .overflow(ov_w));

  mac_pipe_sat #(.A_WIDTH(8), .F_WIDTH(20), .PIPELINED(0), .SATURATE(1)) u_dut_n (
    .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
    .f(f_n), .valid_out(vo_n), .overflow(ov_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int av, input int bv, input logic v, input logic c);
    a         = 8'(av);
    b         = 8'(bv);
    valid_in  = v;
    clear_acc = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t4_a [4] = '{1, 100, 3, -4};
  int t4_b [4] = '{2, 100, 3, 5};
  logic t4_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic t4_c [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  int t4_f [4] = '{2, 2, 11, -9};

  initial begin
    reset = 1'b1;
    drive(0, 0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_f_p", f_p, 0);   chk("rst_vo_p", vo_p, 0); chk("rst_ov_p", ov_p, 0);
    chk("rst_f_w", f_w, 0);   chk("rst_vo_w", vo_w, 0); chk("rst_ov_w", ov_w, 0);
    chk("rst_f_n", f_n, 0);   chk("rst_vo_n", vo_n, 0); chk("rst_ov_n", ov_n, 0);

    // single sample latency
    reset = 1'b0;
    drive(3, 4, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    chk("t1_c1_vo_p", vo_p, 0); chk("t1_c1_vo_n", vo_n, 0);
    step();
    chk("t1_c2_vo_n", vo_n, 1); chk("t1_c2_f_n", f_n, 12); chk("t1_c2_vo_p", vo_p, 0);
    step();
    chk("t1_c3_vo_p", vo_p, 1); chk("t1_c3_f_p", f_p, 12); chk("t1_c3_vo_n", vo_n, 0);
    chk("t1_c3_f_w", f_w, 12);
    step();
    chk("t1_c4_vo_p", vo_p, 0); chk("t1_c4_f_p", f_p, 12);

    // accumulate up to and across the positive limit
    for (int i = 0; i < 31; i++) begin
      drive(-128, -128, 1'b1, i == 0);
      step();
    end
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) step();
    chk("t2_31_f_p", f_p, 507904); chk("t2_31_ov_p", ov_p, 0);
    chk("t2_31_f_w", f_w, 507904); chk("t2_31_ov_w", ov_w, 0);
    chk("t2_31_f_n", f_n, 507904);
    drive(-128, -128, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) step();
    chk("t2_32_f_p", f_p, 524287);  chk("t2_32_ov_p", ov_p, 1);
    chk("t2_32_f_w", f_w, -524288); chk("t2_32_ov_w", ov_w, 1);
    chk("t2_32_f_n", f_n, 524287);  chk("t2_32_ov_n", ov_n, 1);
    drive(-128, -128, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) step();
    chk("t2_33_f_p", f_p, 524287);  chk("t2_33_ov_p", ov_p, 1);
    chk("t2_33_f_w", f_w, -507904); chk("t2_33_ov_w", ov_w, 1);

    // clear drops overflow and restarts the sum
    drive(5, 6, 1'b1, 1'b1);
    step();
    drive(0, 0, 1'b0, 1'b0);
    repeat (3) step();
    chk("t3_f_p", f_p, 30); chk("t3_ov_p", ov_p, 0);
    chk("t3_f_w", f_w, 30); chk("t3_ov_w", ov_w, 0);
    chk("t3_f_n", f_n, 30); chk("t3_ov_n", ov_n, 0);

    // gapped stream: pipelined outputs trail by 2 edges, unpipelined by 1
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(t4_a[i], t4_b[i], t4_v[i], t4_c[i]);
      else       drive(0, 0, 1'b0, 1'b0);
      step();
      if (i >= 2 && i <= 5) begin
        chk($sformatf("t4_vo_p%0d", i - 2), vo_p, t4_v[i-2]);
        chk($sformatf("t4_f_p%0d", i - 2), f_p, t4_f[i-2]);
        chk($sformatf("t4_f_w%0d", i - 2), f_w, t4_f[i-2]);
      end
      if (i >= 1 && i <= 4) begin
        chk($sformatf("t4_vo_n%0d", i - 1), vo_n, t4_v[i-1]);
        chk($sformatf("t4_f_n%0d", i - 1), f_n, t4_f[i-1]);
      end
    end

    // reset with samples in flight and a valid sample on the reset edge
    drive(9, 9, 1'b1, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(0, 0, 1'b0, 1'b0);
    chk("t5_f_p", f_p, 0); chk("t5_vo_p", vo_p, 0); chk("t5_ov_p", ov_p, 0);
    chk("t5_f_n", f_n, 0); chk("t5_vo_n", vo_n, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_quiet_p%0d", i), vo_p, 0);
      chk($sformatf("t5_quiet_w%0d", i), vo_w, 0);
      chk($sformatf("t5_quiet_n%0d", i), vo_n, 0);
    end
    drive(7, 7, 1'b1, 1'b0);
    step();
    drive(0, 0, 1'b0, 1'b0);
    step();
    chk("t5_vo_n", vo_n, 1); chk("t5_f_n49", f_n, 49);
    step();
    chk("t5_vo_p", vo_p, 1); chk("t5_f_p49", f_p, 49); chk("t5_f_w49", f_w, 49);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
